// File: rtl/postfix_pkg.sv
// Shared types and constants for the postfix evaluator.
// Optional feature macro: POSTFIX_MOD_EN (enables the '%' operator).
package postfix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_UNDER = 3'd1,
    ERR_OVER  = 3'd2,
    ERR_DIV0  = 3'd3,
    ERR_BADOP = 3'd4,
    ERR_DEPTH = 3'd5
  } err_t;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  localparam logic [7:0] OP_MOD = 8'h25;

  // True when the ASCII token is an operator this build can execute.
  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: ok = 1'b1;
`ifdef POSTFIX_MOD_EN
      OP_MOD:                         ok = 1'b1;
`endif
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/eval_stack.sv
// Register-array operand stack: push, pop-and-overwrite-top, clear,
// with combinational reads of the top and next-to-top entries.
module eval_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop_wr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         clear,
  output logic [WIDTH-1:0]             top_data,
  output logic [WIDTH-1:0]             nos_data,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] nos_idx;

  assign full    = (depth == CNT_W'(DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = PTR_W'(depth - CNT_W'(1));
  assign nos_idx = PTR_W'(depth - CNT_W'(2));

  // Reads are masked to zero when the addressed entry does not exist.
  always_comb begin
    top_data = '0;
    nos_data = '0;
    if (depth >= CNT_W'(1)) top_data = mem[top_idx];
    if (depth >= CNT_W'(2)) nos_data = mem[nos_idx];
  end

  // Storage and depth update; push has precedence over pop_wr.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      depth <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[PTR_W'(depth)] <= push_data;
      depth              <= depth + CNT_W'(1);
    end else if (pop_wr && (depth >= CNT_W'(2))) begin
      mem[nos_idx] <= wr_data;
      depth        <= depth - CNT_W'(1);
    end
  end

endmodule

// File: rtl/postfix_eval.sv
// Postfix expression evaluator: numbers push, operators pop two and push
// the result, END presents the result or the first error on a strobe/ack port.
// Optional feature macro: POSTFIX_MOD_EN (signed remainder operator '%').
module postfix_eval
  import postfix_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       NUM_IN,
  input  logic             NUM_STB,
  output logic             NUM_ACK,
  input  logic [7:0]       SIGN_IN,
  input  logic             SIGN_STB,
  output logic             SIGN_ACK,
  input  logic             END_STB,
  output logic             END_ACK,
  output logic [WIDTH-1:0] RESULT,
  output logic [2:0]       ERROR,
  output logic             RESULT_STB,
  input  logic             RESULT_ACK,
  output logic             BUSY
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  err_t             err_q, err_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] result_q, result_d;
  err_t             error_q, error_d;
  logic             rstb_q, rstb_d;
  logic             busy_q;

  logic             push_c, pop_wr_c, clear_c;
  logic             num_ack_c, sign_ack_c, end_ack_c;
  logic [WIDTH-1:0] stk_top, stk_nos;
  logic [CNT_W-1:0] stk_depth;
  logic             stk_full, stk_empty;
  logic             under_c;

  logic signed [WIDTH-1:0] a_s, b_s, alu_c;
  logic                    div0_c;

  eval_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_c),
    .push_data (WIDTH'(NUM_IN)),
    .pop_wr    (pop_wr_c),
    .wr_data   (alu_q),
    .clear     (clear_c),
    .top_data  (stk_top),
    .nos_data  (stk_nos),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign a_s     = stk_nos;
  assign b_s     = stk_top;
  assign under_c = stk_empty || (stk_depth == CNT_W'(1));

  // ALU: a = next-to-top, b = top; +,-,* wrap, / and % truncate toward zero.
  always_comb begin
    alu_c  = '0;
    div0_c = 1'b0;
    case (op_q)
      OP_ADD: alu_c = a_s + b_s;
      OP_SUB: alu_c = a_s - b_s;
      OP_MUL: alu_c = a_s * b_s;
      OP_DIV: begin
        if (b_s == '0) div0_c = 1'b1;
        else           alu_c  = a_s / b_s;
      end
`ifdef POSTFIX_MOD_EN
      OP_MOD: begin
        if (b_s == '0) div0_c = 1'b1;
        else           alu_c  = a_s % b_s;
      end
`endif
      default: alu_c = '0;
    endcase
  end

  // Next-state, token handshakes and stack control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_d      = err_q;
    alu_d      = alu_q;
    result_d   = result_q;
    error_d    = error_q;
    rstb_d     = rstb_q;
    push_c     = 1'b0;
    pop_wr_c   = 1'b0;
    clear_c    = 1'b0;
    num_ack_c  = 1'b0;
    sign_ack_c = 1'b0;
    end_ack_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (NUM_STB) begin
          num_ack_c = 1'b1;
          if (err_q == ERR_NONE) begin
            if (stk_full) err_d  = ERR_OVER;
            else          push_c = 1'b1;
          end
        end else if (SIGN_STB) begin
          sign_ack_c = 1'b1;
          if (err_q == ERR_NONE) begin
            if (under_c) begin
              err_d = ERR_UNDER;
            end else if (!op_legal(SIGN_IN)) begin
              err_d = ERR_BADOP;
            end else begin
              op_d    = SIGN_IN;
              state_d = EXEC;
            end
          end
        end else if (END_STB) begin
          end_ack_c = 1'b1;
          rstb_d    = 1'b1;
          state_d   = DONE;
          if (err_q != ERR_NONE) begin
            error_d  = err_q;
            result_d = '0;
          end else if (stk_depth != CNT_W'(1)) begin
            error_d  = ERR_DEPTH;
            result_d = '0;
          end else begin
            error_d  = ERR_NONE;
            result_d = stk_top;
          end
        end
      end
      EXEC: begin
        if (div0_c) begin
          err_d   = ERR_DIV0;
          state_d = IDLE;
        end else begin
          alu_d   = alu_c;
          state_d = WRITE;
        end
      end
      WRITE: begin
        pop_wr_c = 1'b1;
        state_d  = IDLE;
      end
      DONE: begin
        if (RESULT_ACK) begin
          clear_c  = 1'b1;
          err_d    = ERR_NONE;
          rstb_d   = 1'b0;
          result_d = '0;
          error_d  = ERR_NONE;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      err_q    <= ERR_NONE;
      alu_q    <= '0;
      result_q <= '0;
      error_q  <= ERR_NONE;
      rstb_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      err_q    <= err_d;
      alu_q    <= alu_d;
      result_q <= result_d;
      error_q  <= error_d;
      rstb_q   <= rstb_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign NUM_ACK    = num_ack_c;
  assign SIGN_ACK   = sign_ack_c;
  assign END_ACK    = end_ack_c;
  assign RESULT     = result_q;
  assign ERROR      = error_q;
  assign RESULT_STB = rstb_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_postfix_eval.sv
// Directed bench for postfix_eval (WIDTH=16, DEPTH=8).
module tb_postfix_eval;

  localparam int K_NUM  = 0;
  localparam int K_SIGN = 1;
  localparam int K_END  = 2;

  logic        CLK, RST;
  logic [7:0]  NUM_IN, SIGN_IN;
  logic        NUM_STB, SIGN_STB, END_STB, RESULT_ACK;
  logic        NUM_ACK, SIGN_ACK, END_ACK, RESULT_STB, BUSY;
  logic [15:0] RESULT;
  logic [2:0]  ERROR;

  int total = 0;
  int bad   = 0;

  postfix_eval #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .NUM_IN     (NUM_IN),
    .NUM_STB    (NUM_STB),
    .NUM_ACK    (NUM_ACK),
    .SIGN_IN    (SIGN_IN),
    .SIGN_STB   (SIGN_STB),
    .SIGN_ACK   (SIGN_ACK),
    .END_STB    (END_STB),
    .END_ACK    (END_ACK),
    .RESULT     (RESULT),
    .ERROR      (ERROR),
    .RESULT_STB (RESULT_STB),
    .RESULT_ACK (RESULT_ACK),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one token and wait (bounded) for its ACK; returns at posedge+1.
  task automatic xfer(input int kind, input logic [7:0] v);
    bit got;
    logic ack;
    got = 1'b0;
    @(negedge CLK);
    case (kind)
      K_NUM:   begin NUM_IN  = v; NUM_STB  = 1'b1; end
      K_SIGN:  begin SIGN_IN = v; SIGN_STB = 1'b1; end
      default: END_STB = 1'b1;
    endcase
    for (int n = 0; n < 40; n++) begin
      #1;
      case (kind)
        K_NUM:   ack = NUM_ACK;
        K_SIGN:  ack = SIGN_ACK;
        default: ack = END_ACK;
      endcase
      if (ack) begin
        got = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check($sformatf("ack kind%0d tok%0h", kind, v), 32'(got), 32'd1);
    if (got) begin
      @(posedge CLK);
      #1;
    end
    NUM_STB  = 1'b0;
    SIGN_STB = 1'b0;
    END_STB  = 1'b0;
  endtask

  // Wait for the result strobe, check payload and hold, then acknowledge.
  task automatic get_result(input string tag, input logic [15:0] exp_res, input logic [2:0] exp_err);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      #1;
      if (RESULT_STB) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".stb"},  32'(got),    32'd1);
    check({tag, ".res"},  32'(RESULT), 32'(exp_res));
    check({tag, ".err"},  32'(ERROR),  32'(exp_err));
    check({tag, ".busy"}, 32'(BUSY),   32'd1);
    repeat (2) @(negedge CLK);
    #1;
    check({tag, ".hold_stb"}, 32'(RESULT_STB), 32'd1);
    check({tag, ".hold_res"}, 32'(RESULT),     32'(exp_res));
    check({tag, ".no_ack"},   32'(NUM_ACK | SIGN_ACK | END_ACK), 32'd0);
    RESULT_ACK = 1'b1;
    @(posedge CLK);
    #1;
    RESULT_ACK = 1'b0;
    check({tag, ".stb_clr"},  32'(RESULT_STB), 32'd0);
    check({tag, ".idle"},     32'(BUSY),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sign_cnt, num_cyc, s1, s2, end_cyc, multi;
    bit done;
    logic na, sa, ea;

    RST = 1'b1; NUM_IN = '0; SIGN_IN = '0;
    NUM_STB = 1'b0; SIGN_STB = 1'b0; END_STB = 1'b0; RESULT_ACK = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst.result", 32'(RESULT),     32'd0);
    check("rst.error",  32'(ERROR),      32'd0);
    check("rst.stb",    32'(RESULT_STB), 32'd0);
    check("rst.busy",   32'(BUSY),       32'd0);
    check("rst.acks",   32'(NUM_ACK | SIGN_ACK | END_ACK), 32'd0);
    RST = 1'b0;

    // 3 4 + 2 * -> 14
    xfer(K_NUM, 8'd3); xfer(K_NUM, 8'd4); xfer(K_SIGN, 8'h2B);
    xfer(K_NUM, 8'd2); xfer(K_SIGN, 8'h2A); xfer(K_END, 8'd0);
    get_result("add_mul", 16'd14, 3'd0);

    // 2 7 - 2 / -> -5/2 = -2
    xfer(K_NUM, 8'd2); xfer(K_NUM, 8'd7); xfer(K_SIGN, 8'h2D);
    xfer(K_NUM, 8'd2); xfer(K_SIGN, 8'h2F); xfer(K_END, 8'd0);
    get_result("neg_div", 16'hFFFE, 3'd0);

    // 7 2 - -> 5
    xfer(K_NUM, 8'd7); xfer(K_NUM, 8'd2); xfer(K_SIGN, 8'h2D); xfer(K_END, 8'd0);
    get_result("sub", 16'd5, 3'd0);

    // 200 200 * -> 40000 mod 2^16 = 0x9C40
    xfer(K_NUM, 8'd200); xfer(K_NUM, 8'd200); xfer(K_SIGN, 8'h2A); xfer(K_END, 8'd0);
    get_result("mul_wrap", 16'h9C40, 3'd0);

    // 8 0 / 5 + -> div by zero; later tokens still acked
    xfer(K_NUM, 8'd8); xfer(K_NUM, 8'd0); xfer(K_SIGN, 8'h2F);
    xfer(K_NUM, 8'd5); xfer(K_SIGN, 8'h2B); xfer(K_END, 8'd0);
    get_result("div0", 16'd0, 3'd3);
    xfer(K_END, 8'd0);
    get_result("div0_cleared", 16'd0, 3'd5);

    // '+' on empty stack -> underflow
    xfer(K_SIGN, 8'h2B); xfer(K_END, 8'd0);
    get_result("underflow", 16'd0, 3'd1);

    // nine numbers into an 8-deep stack -> overflow
    for (int i = 1; i <= 9; i++) xfer(K_NUM, 8'(i));
    xfer(K_END, 8'd0);
    get_result("overflow", 16'd0, 3'd2);

    // 1 2 END -> depth error
    xfer(K_NUM, 8'd1); xfer(K_NUM, 8'd2); xfer(K_END, 8'd0);
    get_result("depth", 16'd0, 3'd5);

    // unknown operator '^'
    xfer(K_NUM, 8'd1); xfer(K_NUM, 8'd2); xfer(K_SIGN, 8'h5E); xfer(K_END, 8'd0);
    get_result("badop", 16'd0, 3'd4);

    // all strobes at once with stack [5,6]: NUM, SIGN, (3-cycle op), SIGN, END
    xfer(K_NUM, 8'd5); xfer(K_NUM, 8'd6);
    @(negedge CLK);
    NUM_IN = 8'd10; SIGN_IN = 8'h2B;
    NUM_STB = 1'b1; SIGN_STB = 1'b1; END_STB = 1'b1;
    sign_cnt = 0; num_cyc = -1; s1 = -1; s2 = -1; end_cyc = -1; multi = 0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      #1;
      na = NUM_ACK; sa = SIGN_ACK; ea = END_ACK;
      if (int'(na) + int'(sa) + int'(ea) > 1) multi++;
      if (na) num_cyc = c;
      if (sa) begin
        if (sign_cnt == 0) s1 = c;
        else               s2 = c;
        sign_cnt++;
      end
      if (ea) end_cyc = c;
      @(posedge CLK);
      #1;
      if (na) NUM_STB = 1'b0;
      if (sa && sign_cnt == 2) SIGN_STB = 1'b0;
      if (ea) begin
        END_STB = 1'b0;
        done = 1'b1;
      end
      if (!done) @(negedge CLK);
    end
    NUM_STB = 1'b0; SIGN_STB = 1'b0; END_STB = 1'b0;
    check("prio.one_ack", 32'(multi),   32'd0);
    check("prio.num_cyc", 32'(num_cyc), 32'd0);
    check("prio.s1_cyc",  32'(s1),      32'd1);
    check("prio.s2_cyc",  32'(s2),      32'd4);
    check("prio.end_cyc", 32'(end_cyc), 32'd7);
    get_result("prio", 16'd21, 3'd0);

    // reset while executing an operator
    xfer(K_NUM, 8'd1); xfer(K_NUM, 8'd2); xfer(K_SIGN, 8'h2B);
    check("exec.busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mid.busy",   32'(BUSY),       32'd0);
    check("rst_mid.stb",    32'(RESULT_STB), 32'd0);
    check("rst_mid.result", 32'(RESULT),     32'd0);
    check("rst_mid.error",  32'(ERROR),      32'd0);
    xfer(K_END, 8'd0);
    get_result("rst_mid_empty", 16'd0, 3'd5);
    xfer(K_NUM, 8'd9); xfer(K_END, 8'd0);
    get_result("after_rst", 16'd9, 3'd0);

    // remainder operator
    xfer(K_NUM, 8'd7); xfer(K_NUM, 8'd3); xfer(K_SIGN, 8'h25); xfer(K_END, 8'd0);
`ifdef POSTFIX_MOD_EN
    get_result("mod", 16'd1, 3'd0);
`else
    get_result("mod", 16'd0, 3'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
